// File: rtl/mux_scan_if.sv
// Bundle of producer, mux and serial-consumer signals around the scan sequencer.
// The slave side is the sequencer; the master side is everything around it.
interface mux_scan_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
);
  logic             start;
  logic [WIDTH-1:0] word_in;
  logic             dir;
  logic             abort;
  logic [WIDTH-1:0] mux_d;
  logic [SEL_W-1:0] mux_s;
  logic             mux_en;
  logic             mux_y;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  start, word_in, dir, abort, mux_y, bit_ready,
    output mux_d, mux_s, mux_en, bit_out, bit_valid, busy, done
  );

  modport master (
    output start, word_in, dir, abort, mux_y, bit_ready,
    input  mux_d, mux_s, mux_en, bit_out, bit_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 32:1 enable-gated bit-select mux.
// Latches a word, presents it on the mux data bus, walks the select through
// every index in the latched direction, samples Y after a settle window and
// hands each sampled bit to a serial consumer over valid/ready.
module mux_scan_ctrl #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5,
  parameter int DWELL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_scan_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Counter only has to reach DWELL-1, so it never needs more than clog2(DWELL) bits.
  localparam int               CNT_W     = (DWELL < 2) ? 1 : $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_FIRST = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

  state_t           state_r;
  state_t           next_state_s;

  logic [WIDTH-1:0] mux_d_r,     mux_d_s;
  logic [SEL_W-1:0] mux_s_r,     mux_s_s;
  logic             mux_en_r,    mux_en_s;
  logic             bit_out_r,   bit_out_s;
  logic             bit_valid_r, bit_valid_s;
  logic             busy_r,      busy_s;
  logic             done_r,      done_s;
  logic [CNT_W-1:0] dwell_cnt_r, dwell_cnt_s;
  logic             dir_r,       dir_s;

  logic             xfer_s;
  logic             settle_end_s;
  logic             last_idx_s;

  assign xfer_s       = bit_valid_r && bus.bit_ready;
  assign settle_end_s = (dwell_cnt_r == CNT_LAST);
  // The final index depends on the direction latched with the word, never the live input.
  assign last_idx_s   = dir_r ? (mux_s_r == SEL_FIRST) : (mux_s_r == SEL_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; abort outranks both the settle timeout and a handshake.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = SETTLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          next_state_s = IDLE;
        end else if (settle_end_s) begin
          next_state_s = PRESENT;
        end else begin
          next_state_s = SETTLE;
        end
      end
      PRESENT: begin
        if (bus.abort) begin
          next_state_s = IDLE;
        end else if (xfer_s) begin
          next_state_s = last_idx_s ? DONE : SETTLE;
        end else begin
          next_state_s = PRESENT;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; everything holds unless a state acts on it.
  always_comb begin
    mux_d_s     = mux_d_r;
    mux_s_s     = mux_s_r;
    mux_en_s    = mux_en_r;
    bit_out_s   = bit_out_r;
    bit_valid_s = bit_valid_r;
    dwell_cnt_s = dwell_cnt_r;
    dir_s       = dir_r;
    done_s      = 1'b0;
    busy_s      = (next_state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          mux_d_s     = bus.word_in;
          mux_s_s     = bus.dir ? SEL_LAST : SEL_FIRST;
          dir_s       = bus.dir;
          dwell_cnt_s = CNT_ZERO;
          mux_en_s    = 1'b1;
        end else begin
          mux_en_s    = 1'b0;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          mux_en_s    = 1'b0;
          bit_valid_s = 1'b0;
        end else if (settle_end_s) begin
          bit_out_s   = bus.mux_y;
          bit_valid_s = 1'b1;
        end else begin
          dwell_cnt_s = dwell_cnt_r + CNT_ONE;
        end
      end
      PRESENT: begin
        if (bus.abort) begin
          mux_en_s    = 1'b0;
          bit_valid_s = 1'b0;
        end else if (xfer_s) begin
          bit_valid_s = 1'b0;
          if (last_idx_s) begin
            done_s = 1'b1;
          end else begin
            mux_s_s     = dir_r ? (mux_s_r - SEL_ONE) : (mux_s_r + SEL_ONE);
            dwell_cnt_s = CNT_ZERO;
          end
        end else begin
          bit_valid_s = 1'b1;
        end
      end
      DONE: begin
        mux_en_s    = 1'b0;
        bit_valid_s = 1'b0;
      end
      default: begin
        mux_en_s    = 1'b0;
        bit_valid_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_d_r     <= {WIDTH{1'b0}};
      mux_s_r     <= {SEL_W{1'b0}};
      mux_en_r    <= 1'b0;
      bit_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dwell_cnt_r <= CNT_ZERO;
      dir_r       <= 1'b0;
    end else begin
      mux_d_r     <= mux_d_s;
      mux_s_r     <= mux_s_s;
      mux_en_r    <= mux_en_s;
      bit_out_r   <= bit_out_s;
      bit_valid_r <= bit_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      dwell_cnt_r <= dwell_cnt_s;
      dir_r       <= dir_s;
    end
  end

  assign bus.mux_d     = mux_d_r;
  assign bus.mux_s     = mux_s_r;
  assign bus.mux_en    = mux_en_r;
  assign bus.bit_out   = bit_out_r;
  assign bus.bit_valid = bit_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: expected bits are queued when a word is
// started, a negedge monitor logs every accepted bit, and each scenario task
// compares the logged stream against the queue.
module tb_mux_scan_ctrl;
  localparam int WIDTH = 32;
  localparam int SEL_W = 5;
  localparam int DWELL = 2;
  localparam int BIT_CYC = DWELL + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux_scan_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  mux_scan_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 32:1 enable-gated mux.
  assign bus.mux_y = bus.mux_en ? bus.mux_d[bus.mux_s] : 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit exp_q[$];
  bit rx_q[$];
  logic [SEL_W-1:0] rx_sel_q[$];

  // Monitor: log each bit the consumer accepts, and count done pulses.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.bit_valid === 1'b1 && bus.bit_ready === 1'b1 && bus.abort === 1'b0) begin
        rx_q.push_back(bus.bit_out);
        rx_sel_q.push_back(bus.mux_s);
      end
      if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input logic d);
    logic [WIDTH-1:0] wv;
    wv = w;
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(wv[d ? (WIDTH - 1 - i) : i]);
  endtask

  task automatic start_word(input logic [WIDTH-1:0] w, input logic d);
    bus.word_in = w;
    bus.dir = d;
    bus.start = 1'b1;
    push_word(w, d);
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      cyc();
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [WIDTH+SEL_W+4:0] outs;
    outs = {bus.mux_d, bus.mux_s, bus.mux_en, bus.bit_out, bus.bit_valid, bus.busy, bus.done};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_values: got %0h expected 0", outs);
    end
    rst_n = 1'b1;
    cyc();
    start_word(32'h6969_6969, 1'b0);
    cyc();
    checks++;
    if (bus.mux_en !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_settle: got en=%b busy=%b expected en=1 busy=1", bus.mux_en, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    outs = {bus.mux_d, bus.mux_s, bus.mux_en, bus.bit_out, bus.bit_valid, bus.busy, bus.done};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_settle: got %0h expected 0", outs);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (bus.bit_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mux_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_idle: got valid=%b busy=%b en=%b expected 0,0,0",
                 bus.bit_valid, bus.busy, bus.mux_en);
      end
    end
  endtask

  task automatic test_fwd_scan();
    int base, d0, n, cnt;
    bit seen, e;
    logic [7:0] first8;
    base = rx_q.size();
    d0 = done_cnt;
    bus.bit_ready = 1'b1;
    start_word(32'h6969_6969, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.mux_en !== 1'b1 || bus.mux_s !== 5'd0 || bus.mux_d !== 32'h6969_6969) begin
      failures++;
      $display("FAIL fwd_start: got busy=%b en=%b s=%0d d=%h expected 1,1,0,69696969",
               bus.busy, bus.mux_en, bus.mux_s, bus.mux_d);
    end
    wait_done(200, n, seen);
    checks++;
    if (!seen || n != WIDTH * BIT_CYC) begin
      failures++;
      $display("FAIL fwd_done_latency: got seen=%0d cycles=%0d expected 1,%0d", seen, n, WIDTH * BIT_CYC);
    end
    cnt = rx_q.size() - base;
    checks++;
    if (cnt != WIDTH) begin
      failures++;
      $display("FAIL fwd_bit_count: got %0d expected %0d", cnt, WIDTH);
    end
    if (cnt >= 8) begin
      for (int k = 0; k < 8; k++) first8[7-k] = rx_q[base+k];
      checks++;
      if (first8 !== 8'b1001_0110) begin
        failures++;
        $display("FAIL fwd_first8: got %b expected 10010110", first8);
      end
    end
    for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q[base+i] !== e) begin
        failures++;
        $display("FAIL fwd_bit[%0d]: got %b expected %b", i, rx_q[base+i], e);
      end
    end
    exp_q.delete();
    cyc();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mux_en !== 1'b0 || bus.mux_s !== 5'd31) begin
      failures++;
      $display("FAIL fwd_end_state: got done=%b busy=%b en=%b s=%0d expected 0,0,0,31",
               bus.done, bus.busy, bus.mux_en, bus.mux_s);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL fwd_done_pulses: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_rev_scan();
    int base, n, cnt;
    bit seen, e;
    logic [7:0] first8;
    base = rx_q.size();
    bus.bit_ready = 1'b1;
    start_word(32'h6969_6969, 1'b1);
    checks++;
    if (bus.mux_s !== 5'd31) begin
      failures++;
      $display("FAIL rev_start_sel: got %0d expected 31", bus.mux_s);
    end
    wait_done(200, n, seen);
    checks++;
    if (!seen || n != WIDTH * BIT_CYC) begin
      failures++;
      $display("FAIL rev_done_latency: got seen=%0d cycles=%0d expected 1,%0d", seen, n, WIDTH * BIT_CYC);
    end
    cnt = rx_q.size() - base;
    checks++;
    if (cnt != WIDTH) begin
      failures++;
      $display("FAIL rev_bit_count: got %0d expected %0d", cnt, WIDTH);
    end
    if (cnt >= 8) begin
      for (int k = 0; k < 8; k++) first8[7-k] = rx_q[base+k];
      checks++;
      if (first8 !== 8'b0110_1001) begin
        failures++;
        $display("FAIL rev_first8: got %b expected 01101001", first8);
      end
    end
    for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q[base+i] !== e || rx_sel_q[base+i] !== SEL_W'(WIDTH - 1 - i)) begin
        failures++;
        $display("FAIL rev_bit[%0d]: got bit=%b sel=%0d expected bit=%b sel=%0d",
                 i, rx_q[base+i], rx_sel_q[base+i], e, WIDTH - 1 - i);
      end
    end
    exp_q.delete();
    cyc();
    cyc();
    checks++;
    if (bus.mux_s !== 5'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rev_no_wrap: got s=%0d busy=%b expected 0,0", bus.mux_s, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int base, n, cnt;
    bit seen, found, e, held;
    logic [WIDTH-1:0] w;
    w = 32'hA5C3_0F96;
    base = rx_q.size();
    bus.bit_ready = 1'b1;
    start_word(w, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.bit_valid === 1'b1 && bus.mux_s === 5'd5) found = 1'b1;
      else cyc();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL bp_reach_idx5: got not reached expected reached");
    end
    bus.bit_ready = 1'b0;
    held = bus.bit_out;
    checks++;
    if (held !== w[5]) begin
      failures++;
      $display("FAIL bp_idx5_value: got %b expected %b", held, w[5]);
    end
    for (int i = 0; i < 7; i++) begin
      cyc();
      checks++;
      if (bus.bit_valid !== 1'b1 || bus.bit_out !== held || bus.mux_s !== 5'd5 || bus.mux_d !== w) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%b bit=%b s=%0d expected 1,%b,5",
                 i, bus.bit_valid, bus.bit_out, bus.mux_s, held);
      end
    end
    bus.bit_ready = 1'b1;
    wait_done(200, n, seen);
    cnt = rx_q.size() - base;
    checks++;
    if (!seen || cnt != WIDTH) begin
      failures++;
      $display("FAIL bp_bit_count: got seen=%0d bits=%0d expected 1,%0d", seen, cnt, WIDTH);
    end
    for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q[base+i] !== e || rx_sel_q[base+i] !== SEL_W'(i)) begin
        failures++;
        $display("FAIL bp_bit[%0d]: got bit=%b sel=%0d expected bit=%b sel=%0d",
                 i, rx_q[base+i], rx_sel_q[base+i], e, i);
      end
    end
    exp_q.delete();
    cyc();
  endtask

  task automatic test_abort();
    int base, d0, n, cnt;
    bit seen, found, e;
    base = rx_q.size();
    d0 = done_cnt;
    bus.bit_ready = 1'b1;
    start_word(32'h1234_5678, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.bit_valid === 1'b1 && bus.mux_s === 5'd12) found = 1'b1;
      else cyc();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL abort_reach_idx12: got not reached expected reached");
    end
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mux_en !== 1'b0 || bus.bit_valid !== 1'b0 || bus.done !== 1'b0 || bus.mux_s !== 5'd12) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b en=%b valid=%b done=%b s=%0d expected 0,0,0,0,12",
               bus.busy, bus.mux_en, bus.bit_valid, bus.done, bus.mux_s);
    end
    cnt = rx_q.size() - base;
    checks++;
    if (cnt != 12) begin
      failures++;
      $display("FAIL abort_bit_count: got %0d expected 12", cnt);
    end
    for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q[base+i] !== e) begin
        failures++;
        $display("FAIL abort_bit[%0d]: got %b expected %b", i, rx_q[base+i], e);
      end
    end
    exp_q.delete();
    repeat (4) cyc();
    checks++;
    if (done_cnt != d0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got pulses=%0d busy=%b expected 0,0", done_cnt - d0, bus.busy);
    end
    base = rx_q.size();
    start_word(32'hFFFF_0000, 1'b0);
    checks++;
    if (bus.mux_s !== 5'd0 || bus.mux_d !== 32'hFFFF_0000 || bus.mux_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart: got s=%0d d=%h en=%b expected 0,ffff0000,1", bus.mux_s, bus.mux_d, bus.mux_en);
    end
    wait_done(200, n, seen);
    cnt = rx_q.size() - base;
    checks++;
    if (!seen || cnt != WIDTH) begin
      failures++;
      $display("FAIL abort_restart_count: got seen=%0d bits=%0d expected 1,%0d", seen, cnt, WIDTH);
    end
    for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q[base+i] !== e) begin
        failures++;
        $display("FAIL restart_bit[%0d]: got %b expected %b", i, rx_q[base+i], e);
      end
    end
    exp_q.delete();
    cyc();
  endtask

  task automatic test_ignore_start();
    int base, n, cnt;
    bit seen, found, e;
    logic [WIDTH-1:0] w;
    w = 32'hC0DE_5A5A;
    base = rx_q.size();
    bus.bit_ready = 1'b1;
    start_word(w, 1'b0);
    bus.word_in = 32'h0F0F_0F0F;
    bus.dir = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    checks++;
    if (bus.mux_d !== w || bus.mux_s !== 5'd0) begin
      failures++;
      $display("FAIL ign_settle: got d=%h s=%0d expected %h,0", bus.mux_d, bus.mux_s, w);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.bit_valid === 1'b1) found = 1'b1;
      else cyc();
    end
    bus.word_in = 32'h3333_CCCC;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    checks++;
    if (!found || bus.mux_d !== w || bus.mux_s !== 5'd1) begin
      failures++;
      $display("FAIL ign_present: got found=%0d d=%h s=%0d expected 1,%h,1", found, bus.mux_d, bus.mux_s, w);
    end
    wait_done(200, n, seen);
    cnt = rx_q.size() - base;
    checks++;
    if (!seen || cnt != WIDTH || bus.mux_d !== w) begin
      failures++;
      $display("FAIL ign_complete: got seen=%0d bits=%0d d=%h expected 1,%0d,%h", seen, cnt, bus.mux_d, WIDTH, w);
    end
    for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q[base+i] !== e) begin
        failures++;
        $display("FAIL ign_bit[%0d]: got %b expected %b", i, rx_q[base+i], e);
      end
    end
    exp_q.delete();
    cyc();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.word_in = '0;
    bus.dir = 1'b0;
    bus.abort = 1'b0;
    bus.bit_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) cyc();
    test_reset();
    test_fwd_scan();
    test_rev_scan();
    test_backpressure();
    test_abort();
    test_ignore_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
